// File: rtl/vertex_xform_stage_pkg.sv
// Shared types for the vertex transform stage: 16-bit words, 4-vectors,
// 4x4 matrices stored row-major (word 4*row+col) and the stage FSM states.
package xform_pkg;
   typedef logic [15:0] word_t;
   typedef word_t [3:0] vec4_t;
   typedef word_t [15:0] mat44_t;
   typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;

   // Word 15 sits in the MSBs; diagonal words are 0, 5, 10 and 15
   localparam mat44_t MAT_IDENTITY = {16'd1, 64'd0, 16'd1, 64'd0, 16'd1, 64'd0, 16'd1};
endpackage

// File: rtl/vertex_xform_stage_if.sv
// Matrix-load port plus vertex in/out handshakes of the transform stage.
interface vertex_xform_stage_if;
   import xform_pkg::*;

   logic  mat_we;
   logic  [3:0] mat_addr;
   word_t mat_wdata;
   logic  mat_commit;
   logic  in_valid;
   logic  in_ready;
   vec4_t in_vec;
   logic  out_valid;
   logic  out_ready;
   vec4_t out_vec;
   logic  busy;

   modport master (
      output mat_we, mat_addr, mat_wdata, mat_commit, in_valid, in_vec, out_ready,
      input  in_ready, out_valid, out_vec, busy
   );
   modport slave (
      input  mat_we, mat_addr, mat_wdata, mat_commit, in_valid, in_vec, out_ready,
      output in_ready, out_valid, out_vec, busy
   );
endinterface

// File: rtl/vertex_xform_stage_dot.sv
// Combinational 4-element dot product; products truncate to 16 bits and the
// sum wraps modulo 2^16.
module vec4dotvec4
   import xform_pkg::*;
(
   input  vec4_t a,
   input  vec4_t b,
   output word_t y
);
   always_comb begin
      y = '0;
      for (int j = 0; j < 4; j++)
         y = y + word_t'(a[j] * b[j]);
   end
endmodule

// File: rtl/vertex_xform_stage.sv
// Multiplies each accepted vertex by the active 4x4 matrix, one row per cycle,
// with a double-buffered (shadow/active) matrix updated by commit.
module vertex_xform_stage
   import xform_pkg::*;
#(
   parameter bit IDENTITY_ON_RESET = 1'b1
) (
   input logic clk,
   input logic reset,
   vertex_xform_stage_if.slave bus
);
   localparam mat44_t MAT_RST = IDENTITY_ON_RESET ? MAT_IDENTITY : '0;

   state_t     state;
   logic [1:0] row;
   vec4_t      vtx;
   vec4_t      out_q;
   mat44_t     shadow;
   mat44_t     shadow_nx;
   mat44_t     active;
   logic       pending;
   vec4_t      row_b;
   word_t      dot;
   logic       in_xfer;
   logic       out_xfer;
   logic       copy;

   assign bus.in_ready  = (state == IDLE) || ((state == HOLD) && bus.out_ready);
   assign bus.out_valid = (state == HOLD);
   assign bus.busy      = (state != IDLE) || pending;
   assign bus.out_vec   = out_q;

   assign in_xfer  = bus.in_valid && bus.in_ready;
   assign out_xfer = bus.out_valid && bus.out_ready;
   // The copy is held off while a vertex is mid-row so it sees one matrix
   assign copy     = pending && (state != COMPUTE);

   // A write landing on the copy edge is bypassed into the copied matrix
   always_comb begin
      shadow_nx = shadow;
      if (bus.mat_we)
         shadow_nx[bus.mat_addr] = bus.mat_wdata;
   end

   assign row_b = active[{row, 2'b00} +: 4];

   vec4dotvec4 u_dot (
      .a (vtx),
      .b (row_b),
      .y (dot)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         row     <= 2'd0;
         vtx     <= '0;
         out_q   <= '0;
         pending <= 1'b0;
         shadow  <= MAT_RST;
         active  <= MAT_RST;
      end else begin
         shadow  <= shadow_nx;
         if (copy)
            active <= shadow_nx;
         pending <= copy ? 1'b0 : (pending || bus.mat_commit);

         case (state)
            IDLE: begin
               if (in_xfer) begin
                  vtx   <= bus.in_vec;
                  row   <= 2'd0;
                  state <= COMPUTE;
               end
            end
            COMPUTE: begin
               out_q[row] <= dot;
               row        <= row + 2'd1;
               if (row == 2'd3)
                  state <= HOLD;
            end
            HOLD: begin
               if (out_xfer) begin
                  if (in_xfer) begin
                     vtx   <= bus.in_vec;
                     row   <= 2'd0;
                     state <= COMPUTE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
